// File: rtl/seg_page_sched.sv
// Page scheduler for the 4-digit 7-segment scanner: rotates background pages A/B
// on a dwell timer and lets a transient override message preempt rotation.
module seg_page_sched #(
    parameter int DWELL    = 50_000_000,
    parameter int OVR_TIME = 100_000_000
) (
    input  logic        fin,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] a_digits,
    input  logic [3:0]  a_dp,
    input  logic        a_valid,
    input  logic [15:0] b_digits,
    input  logic [3:0]  b_dp,
    input  logic        b_valid,
    input  logic        ovr_req,
    input  logic [15:0] ovr_digits,
    input  logic [3:0]  ovr_dp,
    output logic        ovr_ack,
    output logic [3:0]  num1,
    output logic [3:0]  num2,
    output logic [3:0]  num3,
    output logic [3:0]  num4,
    output logic [3:0]  dp_n,
    output logic [1:0]  page,
    output logic        page_start
);

    localparam int DW = $clog2(DWELL);
    localparam int OW = $clog2(OVR_TIME);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [OW-1:0] OVR_LAST   = OW'(OVR_TIME - 1);

    // State encodings double as the page code driven to the scanner.
    typedef enum logic [1:0] {
        ST_A     = 2'd0,
        ST_B     = 2'd1,
        ST_OVR   = 2'd2,
        ST_BLANK = 2'd3
    } state_t;

    state_t        state_r, next_state_s;
    state_t        ret_r, next_ret_s;
    logic [DW-1:0] dwell_cnt_r, dwell_nxt_s;
    logic [OW-1:0] ovr_cnt_r, ovr_nxt_s;
    logic [15:0]   ovr_digits_r;
    logic [3:0]    ovr_dp_r;
    logic          dwell_exp_s;
    logic [15:0]   dig_nxt_s;
    logic [3:0]    dp_nxt_s;

    function automatic state_t fallback_from(input state_t from, input logic a_v, input logic b_v);
        state_t res;
        if (from == ST_A) begin
            res = b_v ? ST_B : ST_BLANK;
        end else begin
            res = a_v ? ST_A : ST_BLANK;
        end
        return res;
    endfunction

    function automatic state_t return_to(input state_t ret, input logic a_v, input logic b_v);
        state_t res;
        case (ret)
            ST_A:    res = a_v ? ST_A : fallback_from(ST_A, a_v, b_v);
            ST_B:    res = b_v ? ST_B : fallback_from(ST_B, a_v, b_v);
            default: res = ST_BLANK;
        endcase
        return res;
    endfunction

    // Next-state selection in priority order: override, validity loss, dwell, blank exit.
    always_comb begin
        next_state_s = state_r;
        dwell_exp_s  = 1'b0;
        case (state_r)
            ST_BLANK: begin
                if (a_valid) begin
                    next_state_s = ST_A;
                end else if (b_valid) begin
                    next_state_s = ST_B;
                end else begin
                    next_state_s = ST_BLANK;
                end
            end
            ST_A: begin
                if (!a_valid) begin
                    next_state_s = fallback_from(ST_A, a_valid, b_valid);
                end else if (en && (dwell_cnt_r == DWELL_LAST)) begin
                    dwell_exp_s  = 1'b1;
                    next_state_s = b_valid ? ST_B : ST_A;
                end else begin
                    next_state_s = ST_A;
                end
            end
            ST_B: begin
                if (!b_valid) begin
                    next_state_s = fallback_from(ST_B, a_valid, b_valid);
                end else if (en && (dwell_cnt_r == DWELL_LAST)) begin
                    dwell_exp_s  = 1'b1;
                    next_state_s = a_valid ? ST_A : ST_B;
                end else begin
                    next_state_s = ST_B;
                end
            end
            ST_OVR: begin
                if (ovr_cnt_r == OVR_LAST) begin
                    next_state_s = return_to(ret_r, a_valid, b_valid);
                end else begin
                    next_state_s = ST_OVR;
                end
            end
            default: next_state_s = ST_BLANK;
        endcase

        // A re-accept inside the override keeps the page originally interrupted.
        if (ovr_req) begin
            next_state_s = ST_OVR;
            next_ret_s   = (state_r == ST_OVR) ? ret_r : state_r;
        end else begin
            next_ret_s   = ret_r;
        end
    end

    // Counter updates; any page change or dwell expiry restarts the dwell count.
    always_comb begin
        if ((next_state_s != state_r) || dwell_exp_s) begin
            dwell_nxt_s = {DW{1'b0}};
        end else if (en && ((state_r == ST_A) || (state_r == ST_B))) begin
            dwell_nxt_s = dwell_cnt_r + {{(DW-1){1'b0}}, 1'b1};
        end else begin
            dwell_nxt_s = dwell_cnt_r;
        end

        if (ovr_req || (next_state_s != ST_OVR)) begin
            ovr_nxt_s = {OW{1'b0}};
        end else begin
            ovr_nxt_s = ovr_cnt_r + {{(OW-1){1'b0}}, 1'b1};
        end
    end

    // Content for the page being entered; a fresh accept shows the request content directly.
    always_comb begin
        case (next_state_s)
            ST_A: begin
                dig_nxt_s = a_digits;
                dp_nxt_s  = a_dp;
            end
            ST_B: begin
                dig_nxt_s = b_digits;
                dp_nxt_s  = b_dp;
            end
            ST_OVR: begin
                dig_nxt_s = ovr_req ? ovr_digits : ovr_digits_r;
                dp_nxt_s  = ovr_req ? ovr_dp : ovr_dp_r;
            end
            default: begin
                dig_nxt_s = 16'hFFFF;
                dp_nxt_s  = 4'h0;
            end
        endcase
    end

    // State, counters, override snapshot and registered scanner outputs.
    always_ff @(posedge fin) begin
        if (rst) begin
            state_r      <= ST_BLANK;
            ret_r        <= ST_BLANK;
            dwell_cnt_r  <= {DW{1'b0}};
            ovr_cnt_r    <= {OW{1'b0}};
            ovr_digits_r <= 16'h0000;
            ovr_dp_r     <= 4'h0;
            ovr_ack      <= 1'b0;
            page_start   <= 1'b0;
            page         <= 2'd3;
            {num1, num2, num3, num4} <= 16'hFFFF;
            dp_n         <= 4'h0;
        end else begin
            state_r     <= next_state_s;
            ret_r       <= next_ret_s;
            dwell_cnt_r <= dwell_nxt_s;
            ovr_cnt_r   <= ovr_nxt_s;
            if (ovr_req) begin
                ovr_digits_r <= ovr_digits;
                ovr_dp_r     <= ovr_dp;
            end
            ovr_ack      <= ovr_req;
            page_start   <= ovr_req || (next_state_s != state_r);
            page         <= next_state_s;
            {num1, num2, num3, num4} <= dig_nxt_s;
            dp_n         <= dp_nxt_s;
        end
    end

endmodule

// File: tb/tb_seg_page_sched.sv
// Directed testbench for seg_page_sched with DWELL=4 and OVR_TIME=3.
module tb_seg_page_sched;

    logic        fin = 1'b0;
    logic        rst, en;
    logic [15:0] a_digits, b_digits, ovr_digits;
    logic [3:0]  a_dp, b_dp, ovr_dp;
    logic        a_valid, b_valid, ovr_req;
    logic        ovr_ack, page_start;
    logic [3:0]  num1, num2, num3, num4, dp_n;
    logic [1:0]  page;

    int checks = 0;
    int errors = 0;

    // {page, page_start, ovr_ack, digits, dp}
    wire [23:0] obs   = {page, page_start, ovr_ack, num1, num2, num3, num4, dp_n};
    // {page, ovr_ack, digits}
    wire [18:0] obs_h = {page, ovr_ack, num1, num2, num3, num4};

    seg_page_sched #(.DWELL(4), .OVR_TIME(3)) dut (
        .fin(fin), .rst(rst), .en(en),
        .a_digits(a_digits), .a_dp(a_dp), .a_valid(a_valid),
        .b_digits(b_digits), .b_dp(b_dp), .b_valid(b_valid),
        .ovr_req(ovr_req), .ovr_digits(ovr_digits), .ovr_dp(ovr_dp),
        .ovr_ack(ovr_ack), .num1(num1), .num2(num2), .num3(num3), .num4(num4),
        .dp_n(dp_n), .page(page), .page_start(page_start)
    );

    always #5 fin = ~fin;

    task automatic tick();
        @(posedge fin);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; a_valid = 1'b0; b_valid = 1'b0; ovr_req = 1'b0;
        a_digits = 16'h0; b_digits = 16'h0; ovr_digits = 16'h0;
        a_dp = 4'h0; b_dp = 4'h0; ovr_dp = 4'h0;
        tick(); tick();
        if (obs !== {2'd3, 1'b0, 1'b0, 16'hFFFF, 4'h0}) begin
            $display("FAIL reset_state: got %h want %h", obs, {2'd3, 1'b0, 1'b0, 16'hFFFF, 4'h0}); errors++;
        end
        checks++;
        rst = 1'b0;
        tick();
        if (obs !== {2'd3, 1'b0, 1'b0, 16'hFFFF, 4'h0}) begin
            $display("FAIL reset_idle_blank: got %h want %h", obs, {2'd3, 1'b0, 1'b0, 16'hFFFF, 4'h0}); errors++;
        end
        checks++;
    endtask

    task automatic test_a_only();
        do_reset();
        a_valid = 1'b1; b_valid = 1'b0; a_digits = 16'h1234; a_dp = 4'b0100; en = 1'b1;
        tick();
        if (obs !== {2'd0, 1'b1, 1'b0, 16'h1234, 4'h4}) begin
            $display("FAIL a_enter: got %h want %h", obs, {2'd0, 1'b1, 1'b0, 16'h1234, 4'h4}); errors++;
        end
        checks++;
        for (int j = 1; j <= 6; j++) begin
            tick();
            if (obs !== {2'd0, 1'b0, 1'b0, 16'h1234, 4'h4}) begin
                $display("FAIL a_no_rotate[%0d]: got %h want %h", j, obs, {2'd0, 1'b0, 1'b0, 16'h1234, 4'h4}); errors++;
            end
            checks++;
        end
        a_digits = 16'h5678;
        tick();
        if (obs !== {2'd0, 1'b0, 1'b0, 16'h5678, 4'h4}) begin
            $display("FAIL a_live_update: got %h want %h", obs, {2'd0, 1'b0, 1'b0, 16'h5678, 4'h4}); errors++;
        end
        checks++;
    endtask

    task automatic test_rotate();
        logic [23:0] exp;
        logic [23:0] exp_a;
        logic [23:0] exp_b;
        exp_a = {2'd0, 1'b0, 1'b0, 16'h1234, 4'h4};
        exp_b = {2'd1, 1'b0, 1'b0, 16'hABCD, 4'h9};
        do_reset();
        a_valid = 1'b1; b_valid = 1'b1; en = 1'b1;
        a_digits = 16'h1234; a_dp = 4'h4; b_digits = 16'hABCD; b_dp = 4'h9;
        tick();
        if (obs !== (exp_a | 24'h200000)) begin
            $display("FAIL rot_enter_a: got %h want %h", obs, exp_a | 24'h200000); errors++;
        end
        checks++;
        for (int j = 1; j <= 8; j++) begin
            tick();
            exp = (((j / 4) % 2) == 1) ? exp_b : exp_a;
            if ((j % 4) == 0) exp = exp | 24'h200000;
            if (obs !== exp) begin
                $display("FAIL rot_cycle[%0d]: got %h want %h", j, obs, exp); errors++;
            end
            checks++;
        end
        tick();
        en = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            if (obs !== exp_a) begin
                $display("FAIL rot_en_hold[%0d]: got %h want %h", j, obs, exp_a); errors++;
            end
            checks++;
        end
        en = 1'b1;
        tick(); tick();
        if (obs !== exp_a) begin
            $display("FAIL rot_before_delayed: got %h want %h", obs, exp_a); errors++;
        end
        checks++;
        tick();
        if (obs !== (exp_b | 24'h200000)) begin
            $display("FAIL rot_delayed_switch: got %h want %h", obs, exp_b | 24'h200000); errors++;
        end
        checks++;
    endtask

    task automatic test_override();
        do_reset();
        a_valid = 1'b0; b_valid = 1'b1; en = 1'b1; b_digits = 16'hABCD; b_dp = 4'h9;
        tick();
        if (obs !== {2'd1, 1'b1, 1'b0, 16'hABCD, 4'h9}) begin
            $display("FAIL ovr_pre_b: got %h want %h", obs, {2'd1, 1'b1, 1'b0, 16'hABCD, 4'h9}); errors++;
        end
        checks++;
        ovr_req = 1'b1; ovr_digits = 16'h9876; ovr_dp = 4'h3;
        tick();
        if (obs !== {2'd2, 1'b1, 1'b1, 16'h9876, 4'h3}) begin
            $display("FAIL ovr_accept: got %h want %h", obs, {2'd2, 1'b1, 1'b1, 16'h9876, 4'h3}); errors++;
        end
        checks++;
        ovr_req = 1'b0; ovr_digits = 16'h1111; ovr_dp = 4'hF;
        for (int j = 0; j < 2; j++) begin
            tick();
            if (obs !== {2'd2, 1'b0, 1'b0, 16'h9876, 4'h3}) begin
                $display("FAIL ovr_hold[%0d]: got %h want %h", j, obs, {2'd2, 1'b0, 1'b0, 16'h9876, 4'h3}); errors++;
            end
            checks++;
        end
        tick();
        if (obs !== {2'd1, 1'b1, 1'b0, 16'hABCD, 4'h9}) begin
            $display("FAIL ovr_return_b: got %h want %h", obs, {2'd1, 1'b1, 1'b0, 16'hABCD, 4'h9}); errors++;
        end
        checks++;
        // Held request re-accepts with fresh content each cycle.
        ovr_req = 1'b1; ovr_digits = 16'h2222;
        tick();
        if (obs_h !== {2'd2, 1'b1, 16'h2222}) begin
            $display("FAIL held_first: got %h want %h", obs_h, {2'd2, 1'b1, 16'h2222}); errors++;
        end
        checks++;
        ovr_digits = 16'h3333;
        tick();
        if (obs_h !== {2'd2, 1'b1, 16'h3333}) begin
            $display("FAIL held_second: got %h want %h", obs_h, {2'd2, 1'b1, 16'h3333}); errors++;
        end
        checks++;
        ovr_req = 1'b0;
        tick(); tick();
        if (obs_h !== {2'd2, 1'b0, 16'h3333}) begin
            $display("FAIL held_timer_restart: got %h want %h", obs_h, {2'd2, 1'b0, 16'h3333}); errors++;
        end
        checks++;
        tick();
        if (obs_h !== {2'd1, 1'b0, 16'hABCD}) begin
            $display("FAIL held_return_b: got %h want %h", obs_h, {2'd1, 1'b0, 16'hABCD}); errors++;
        end
        checks++;
    endtask

    task automatic test_ovr_at_expiry();
        do_reset();
        a_valid = 1'b1; b_valid = 1'b1; en = 1'b1;
        a_digits = 16'h1234; a_dp = 4'h4; b_digits = 16'hABCD; b_dp = 4'h9;
        tick(); tick(); tick(); tick();
        ovr_req = 1'b1; ovr_digits = 16'h5555; ovr_dp = 4'h0;
        tick();
        if (obs !== {2'd2, 1'b1, 1'b1, 16'h5555, 4'h0}) begin
            $display("FAIL exp_ovr_wins: got %h want %h", obs, {2'd2, 1'b1, 1'b1, 16'h5555, 4'h0}); errors++;
        end
        checks++;
        ovr_req = 1'b0;
        tick(); tick(); tick();
        if (obs !== {2'd0, 1'b1, 1'b0, 16'h1234, 4'h4}) begin
            $display("FAIL exp_return_a: got %h want %h", obs, {2'd0, 1'b1, 1'b0, 16'h1234, 4'h4}); errors++;
        end
        checks++;
        for (int j = 0; j < 3; j++) begin
            tick();
            if (obs !== {2'd0, 1'b0, 1'b0, 16'h1234, 4'h4}) begin
                $display("FAIL exp_full_dwell[%0d]: got %h want %h", j, obs, {2'd0, 1'b0, 1'b0, 16'h1234, 4'h4}); errors++;
            end
            checks++;
        end
        tick();
        if (obs !== {2'd1, 1'b1, 1'b0, 16'hABCD, 4'h9}) begin
            $display("FAIL exp_then_b: got %h want %h", obs, {2'd1, 1'b1, 1'b0, 16'hABCD, 4'h9}); errors++;
        end
        checks++;
    endtask

    task automatic test_valid_loss();
        do_reset();
        a_valid = 1'b1; b_valid = 1'b0; en = 1'b1;
        a_digits = 16'h1234; a_dp = 4'h4; b_digits = 16'hABCD; b_dp = 4'h9;
        tick();
        a_valid = 1'b0;
        tick();
        if (obs !== {2'd3, 1'b1, 1'b0, 16'hFFFF, 4'h0}) begin
            $display("FAIL loss_to_blank: got %h want %h", obs, {2'd3, 1'b1, 1'b0, 16'hFFFF, 4'h0}); errors++;
        end
        checks++;
        tick();
        if (obs !== {2'd3, 1'b0, 1'b0, 16'hFFFF, 4'h0}) begin
            $display("FAIL loss_stay_blank: got %h want %h", obs, {2'd3, 1'b0, 1'b0, 16'hFFFF, 4'h0}); errors++;
        end
        checks++;
        b_valid = 1'b1;
        tick();
        if (obs !== {2'd1, 1'b1, 1'b0, 16'hABCD, 4'h9}) begin
            $display("FAIL loss_blank_to_b: got %h want %h", obs, {2'd1, 1'b1, 1'b0, 16'hABCD, 4'h9}); errors++;
        end
        checks++;
    endtask

    task automatic test_reset_mid_ovr();
        do_reset();
        a_valid = 1'b1; b_valid = 1'b0; en = 1'b1; a_digits = 16'h1234; a_dp = 4'h4;
        tick();
        ovr_req = 1'b1; ovr_digits = 16'h9876; ovr_dp = 4'h3;
        tick();
        ovr_req = 1'b0; rst = 1'b1;
        tick();
        if (obs !== {2'd3, 1'b0, 1'b0, 16'hFFFF, 4'h0}) begin
            $display("FAIL rst_mid_ovr: got %h want %h", obs, {2'd3, 1'b0, 1'b0, 16'hFFFF, 4'h0}); errors++;
        end
        checks++;
        rst = 1'b0;
        tick();
        if (obs !== {2'd0, 1'b1, 1'b0, 16'h1234, 4'h4}) begin
            $display("FAIL rst_then_a: got %h want %h", obs, {2'd0, 1'b1, 1'b0, 16'h1234, 4'h4}); errors++;
        end
        checks++;
        for (int j = 0; j < 3; j++) begin
            tick();
            if (obs !== {2'd0, 1'b0, 1'b0, 16'h1234, 4'h4}) begin
                $display("FAIL rst_no_resume[%0d]: got %h want %h", j, obs, {2'd0, 1'b0, 1'b0, 16'h1234, 4'h4}); errors++;
            end
            checks++;
        end
    endtask

    initial begin
        test_reset();
        test_a_only();
        test_rotate();
        test_override();
        test_ovr_at_expiry();
        test_valid_loss();
        test_reset_mid_ovr();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
